// File: rtl/i2c_fifo_pkg.sv
// i2c_fifo_pkg
// Shared types, constants and helper functions for the I2C FIFO block's
// clock-domain-crossing pointer logic.
//   ptr_w(addr_size) : pointer width (address bits plus one wrap bit)
//   gray2bin/bin2gray: 32-bit Gray <-> binary conversions. Narrower pointers
//                      are zero-extended, which leaves the result unchanged.
//   SYNC_STAGES_MIN/MAX: legal range of synchronizer depth.
package i2c_fifo_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic int ptr_w(input int addr_size);
        return addr_size + 1;
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_chain_rd.sv
// sync_chain_rd
// Generic N-stage, W-bit flop chain used to bring a Gray-coded pointer into
// the local clock domain. Shared by both pointer synchronizer directions.
// Ports:
//   read_clock_i    : destination-domain clock
//   read_reset_n_i  : asynchronous active-low reset, clears every stage
//   data_in         : asynchronous input (must change one bit at a time)
//   data_out        : output of the last stage
// Nothing sits between stages so each flop gets a full period to resolve.
module sync_chain_rd #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 5
) (
    input  logic             read_clock_i,
    input  logic             read_reset_n_i,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
                    if (!read_reset_n_i) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= data_in;
                    end
                end
            end else begin : g_next
                always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
                    if (!read_reset_n_i) begin
                        stage_reg[gi] <= '0;
                    end else begin
                        stage_reg[gi] <= stage_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign data_out = stage_reg[STAGES-1];

endmodule

// File: rtl/wptr_gray_sync_rd.sv
// wptr_gray_sync_rd
// Carries the Gray-coded write pointer of the async FIFO into the read clock
// domain, decodes it to binary and derives the reader's fill level.
// Ports:
//   read_clock_i            : read-domain clock
//   read_reset_n_i          : asynchronous active-low reset
//   write_pointer_i         : Gray write pointer from the write domain (async)
//   read_pointer_bin_i      : binary read pointer (read domain)
//   err_clear_i             : clears gray_err_o (coherency check build only)
//   write_to_read_pointer_o : synchronized Gray pointer (last sync stage)
//   write_pointer_bin_o     : binary decode of the synchronized pointer
//   fill_level_o            : write pointer minus read pointer, modulo 2^PW
//   ptr_update_o            : pulses in any cycle the decoded pointer changes
//   gray_err_o              : sticky Gray coherency error
// Build option: define WPTR_SYNC_GRAY_CHECK_EN to generate the coherency
// checker; otherwise gray_err_o is tied low and err_clear_i is ignored.
module wptr_gray_sync_rd
    import i2c_fifo_pkg::*;
#(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DECODE_REG  = 1
) (
    input  logic               read_clock_i,
    input  logic               read_reset_n_i,
    input  logic [ADDR_SIZE:0] write_pointer_i,
    input  logic [ADDR_SIZE:0] read_pointer_bin_i,
    input  logic               err_clear_i,
    output logic [ADDR_SIZE:0] write_to_read_pointer_o,
    output logic [ADDR_SIZE:0] write_pointer_bin_o,
    output logic [ADDR_SIZE:0] fill_level_o,
    output logic               ptr_update_o,
    output logic               gray_err_o
);

    localparam int PW = ptr_w(ADDR_SIZE);

    generate
        if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
            $error("wptr_gray_sync_rd: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [PW-1:0] sync_gray;
    logic [PW-1:0] sync_bin;
    logic [PW-1:0] prev_bin_reg;

    sync_chain_rd #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (PW)
    ) u_sync_chain (
        .read_clock_i   (read_clock_i),
        .read_reset_n_i (read_reset_n_i),
        .data_in        (write_pointer_i),
        .data_out       (sync_gray)
    );

    assign write_to_read_pointer_o = sync_gray;

    // Each binary bit is the XOR of all Gray bits at or above it; written
    // per bit so no bit depends on another bit of the same vector.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_decode
            assign sync_bin[gi] = ^sync_gray[PW-1:gi];
        end

        if (DECODE_REG != 0) begin : g_decode_reg
            logic [PW-1:0] bin_reg;
            always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
                if (!read_reset_n_i) begin
                    bin_reg <= '0;
                end else begin
                    bin_reg <= sync_bin;
                end
            end
            assign write_pointer_bin_o = bin_reg;
        end else begin : g_decode_comb
            assign write_pointer_bin_o = sync_bin;
        end
    endgenerate

    // Unsigned subtraction wraps naturally, so a wrapped writer still
    // yields the correct positive distance.
    assign fill_level_o = write_pointer_bin_o - read_pointer_bin_i;

    // Previous value resets to 0, so the first cycle after reset only pulses
    // when the decoded pointer is already nonzero.
    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            prev_bin_reg <= '0;
        end else begin
            prev_bin_reg <= write_pointer_bin_o;
        end
    end

    assign ptr_update_o = (write_pointer_bin_o != prev_bin_reg);

`ifdef WPTR_SYNC_GRAY_CHECK_EN
    logic [PW-1:0] gray_prev_reg;
    logic [PW-1:0] gray_diff;
    logic          multi_bit_step;
    logic          fill_overrange;
    logic          err_set;
    logic          err_reg;
    logic          err_next;

    assign gray_diff      = sync_gray ^ gray_prev_reg;
    // Clearing the lowest set bit leaves something only if two or more
    // bits flipped, i.e. Hamming distance above one.
    assign multi_bit_step = |(gray_diff & (gray_diff - 1'b1));
    // Above 2^ADDR_SIZE means the MSB is set together with any lower bit.
    assign fill_overrange = fill_level_o[PW-1] & (|fill_level_o[PW-2:0]);
    assign err_set        = multi_bit_step | fill_overrange;

    always_comb begin
        err_next = err_reg;
        if (err_clear_i) begin
            err_next = 1'b0;
        end
        if (err_set) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            gray_prev_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            gray_prev_reg <= sync_gray;
            err_reg       <= err_next;
        end
    end

    assign gray_err_o = err_reg;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear_i;
    assign gray_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_gray_sync_rd.sv
module tb_wptr_gray_sync_rd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] wp = '0;
    logic [4:0] rp = '0;
    logic       err_clear = 1'b0;
    logic [4:0] sync_gray;
    logic [4:0] wbin;
    logic [4:0] fill;
    logic       upd;
    logic       gerr;

    int vec_count = 0;
    int miss_count = 0;

    typedef struct {
        int bin;
        int fill;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    wptr_gray_sync_rd #(
        .ADDR_SIZE   (4),
        .SYNC_STAGES (2),
        .DECODE_REG  (1)
    ) dut (
        .read_clock_i            (clk),
        .read_reset_n_i          (rst_n),
        .write_pointer_i         (wp),
        .read_pointer_bin_i      (rp),
        .err_clear_i             (err_clear),
        .write_to_read_pointer_o (sync_gray),
        .write_pointer_bin_o     (wbin),
        .fill_level_o            (fill),
        .ptr_update_o            (upd),
        .gray_err_o              (gerr)
    );

    task automatic check(input string name, input int act, input int exp);
        vec_count++;
        if (act != exp) begin
            miss_count++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [4:0] to_gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    // Drive one Gray step, queue the expected decoded pointer and fill level,
    // then leave room for the 3-cycle latency.
    task automatic step(input int b, input int exp_fill);
        exp_t e;
        wp = to_gray(b);
        e.bin = b;
        e.fill = exp_fill;
        exp_q.push_back(e);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every update pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && upd) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("FAIL unexpected_pulse: got pulse with bin %0d, required no pulse", wbin);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_bin", int'(wbin), e.bin);
                check("pulse_fill", int'(fill), e.fill);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_sync_gray", int'(sync_gray), 0);
        check("rst_wbin", int'(wbin), 0);
        check("rst_fill", int'(fill), 0);
        check("rst_upd", int'(upd), 0);
        check("rst_gerr", int'(gerr), 0);
        rp = 5'd3;
        #1 check("rst_fill_rp3", int'(fill), 29);
        rp = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: pointer held at 0 for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_wbin", int'(wbin), 0);
            check("idle_upd", int'(upd), 0);
        end

        // Latency of the first step: exactly 3 clocks
        begin
            exp_t e;
            wp = 5'b00001;
            e.bin = 1;
            e.fill = 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        check("lat_c1_wbin", int'(wbin), 0);
        @(negedge clk);
        check("lat_c2_wbin", int'(wbin), 0);
        check("lat_c2_sync", int'(sync_gray), 1);
        @(negedge clk);
        check("lat_c3_wbin", int'(wbin), 1);
        check("lat_c3_upd", int'(upd), 1);
        @(negedge clk);
        check("lat_c4_upd", int'(upd), 0);

        // Walk through all remaining Gray codes and back to 0, rbin = 0
        for (int i = 2; i <= 32; i++) begin
            step(i % 32, i % 32);
        end
        check("walk_end_wbin", int'(wbin), 0);
        check("walk_end_sync", int'(sync_gray), 0);

        // Wrap: rbin = 31, wbin 0 -> 1
        rp = 5'd31;
        #1 check("wrap_fill_w0", int'(fill), 1);
        step(1, 2);
        check("wrap_fill_w1", int'(fill), 2);

        // Full: rbin = 0, walk wbin up to 16
        rp = 5'd0;
        for (int i = 2; i <= 16; i++) begin
            step(i, i);
        end
        check("full_fill", int'(fill), 16);
        rp = 5'd16;
        #1 check("empty_fill", int'(fill), 0);
        rp = 5'd0;

        // Walk back down to 10
        for (int i = 15; i >= 10; i--) begin
            step(i, i);
        end
        check("pre_rst_wbin", int'(wbin), 10);

        // Asynchronous reset away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("arst_wbin", int'(wbin), 0);
        check("arst_sync", int'(sync_gray), 0);
        check("arst_fill", int'(fill), 0);
        check("arst_upd", int'(upd), 0);
        @(negedge clk);
        begin
            exp_t e;
            e.bin = 10;
            e.fill = 10;
            exp_q.push_back(e);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_c2_wbin", int'(wbin), 0);
        @(negedge clk);
        check("rel_c3_wbin", int'(wbin), 10);
        check("rel_c3_upd", int'(upd), 1);
        repeat (2) @(negedge clk);

`ifdef WPTR_SYNC_GRAY_CHECK_EN
        // Coherency checker: two-bit jump 00000 -> 00011
        rst_n = 1'b0;
        wp = 5'b00000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("gerr_idle", int'(gerr), 0);
        begin
            exp_t e;
            wp = 5'b00011;
            e.bin = 2;
            e.fill = 2;
            exp_q.push_back(e);
        end
        repeat (2) @(negedge clk);
        check("gerr_c2", int'(gerr), 0);
        @(negedge clk);
        check("gerr_c3_set", int'(gerr), 1);
        repeat (3) @(negedge clk);
        check("gerr_sticky", int'(gerr), 1);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("gerr_cleared", int'(gerr), 0);
        begin
            exp_t e;
            wp = 5'b00000;
            e.bin = 0;
            e.fill = 0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("gerr_set_wins", int'(gerr), 1);
        repeat (2) @(negedge clk);
`else
        check("gerr_tied_low", int'(gerr), 0);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
